// File: rtl/bmr_tdee_qsys_nios2_qsys_0_div_cell_pkg.sv
// Shared types and constants for the Nios II iterative divide cell.
package bmr_tdee_qsys_nios2_qsys_0_div_cell_pkg;
    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);
    localparam logic [DIV_DATA_W-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_e;
endpackage

// File: rtl/bmr_tdee_qsys_nios2_qsys_0_div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, try to subtract the divisor.
module bmr_tdee_qsys_nios2_qsys_0_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dvd_msb,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              q_bit
);
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // The full rem is kept in the shift so divisors above 2^(DATA_W-1) still work;
    // a borrow out of the top bit means the trial went negative.
    assign shifted  = {rem, dvd_msb};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[DATA_W];
    assign rem_next = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
endmodule

// File: rtl/bmr_tdee_qsys_nios2_qsys_0_div_cell.sv
// Iterative 32-bit div/divu cell: one quotient bit per cycle, start/done handshake.
module bmr_tdee_qsys_nios2_qsys_0_div_cell
    import bmr_tdee_qsys_nios2_qsys_0_div_cell_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A_div_start,
    input  logic              A_div_signed,
    input  logic [DATA_W-1:0] A_div_src1,
    input  logic [DATA_W-1:0] A_div_src2,
    output logic              A_div_busy,
    output logic              A_div_done,
    output logic [DATA_W-1:0] A_div_quot,
    output logic [DATA_W-1:0] A_div_rem,
    output logic              A_div_by_zero
);
    localparam int CNT_W = $clog2(DATA_W);

    div_state_e        state, state_nxt;
    logic [DATA_W-1:0] src1_q, src2_q;
    logic [DATA_W-1:0] dvd, dvs, prem, prem_nxt;
    logic [DATA_W-1:0] fix_quot, fix_rem;
    logic [CNT_W-1:0]  cnt;
    logic              sgn_q, neg_q, neg_r, q_bit, last;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic s);
        return (s && x[DATA_W-1]) ? -x : x;
    endfunction

    // Quotient bits shift into the bottom of dvd as dividend bits leave the top.
    bmr_tdee_qsys_nios2_qsys_0_div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (prem),
        .dvd_msb  (dvd[DATA_W-1]),
        .divisor  (dvs),
        .rem_next (prem_nxt),
        .q_bit    (q_bit)
    );

    assign last     = (cnt == CNT_W'(DATA_W-1));
    assign fix_quot = neg_q ? -dvd : dvd;
    assign fix_rem  = neg_r ? -prem : prem;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (A_div_start) state_nxt = PREP;
            PREP:    state_nxt = ITER;
            ITER:    if (last) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            A_div_busy    <= 1'b0;
            A_div_done    <= 1'b0;
            A_div_quot    <= '0;
            A_div_rem     <= '0;
            A_div_by_zero <= 1'b0;
            src1_q        <= '0;
            src2_q        <= '0;
            sgn_q         <= 1'b0;
            dvd           <= '0;
            dvs           <= '0;
            prem          <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
        end else begin
            state      <= state_nxt;
            A_div_done <= 1'b0;
            // Lags the state by one edge so busy covers E1 through the done cycle.
            A_div_busy <= (state != IDLE);
            case (state)
                IDLE: if (A_div_start) begin
                    src1_q <= A_div_src1;
                    src2_q <= A_div_src2;
                    sgn_q  <= A_div_signed;
                end
                PREP: begin
                    dvd   <= mag(src1_q, sgn_q);
                    dvs   <= mag(src2_q, sgn_q);
                    neg_q <= sgn_q & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
                    neg_r <= sgn_q & src1_q[DATA_W-1];
                    prem  <= '0;
                    cnt   <= '0;
                end
                ITER: begin
                    prem <= prem_nxt;
                    dvd  <= {dvd[DATA_W-2:0], q_bit};
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    A_div_done <= 1'b1;
                    if (src2_q == '0) begin
                        A_div_quot    <= {DATA_W{DIV0_QUOT[0]}};
                        A_div_rem     <= src1_q;
                        A_div_by_zero <= 1'b1;
                    end else begin
                        A_div_quot    <= fix_quot;
                        A_div_rem     <= fix_rem;
                        A_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bmr_tdee_qsys_nios2_qsys_0_div_cell.sv
// Self-checking bench for the iterative divide cell: directed table, corner sequences, random vs model.
module tb_bmr_tdee_qsys_nios2_qsys_0_div_cell;
    logic        clk = 1'b0;
    logic        reset, start, sgn;
    logic [31:0] src1, src2;
    logic        busy, done, by_zero;
    logic [31:0] quot, rem;

    always #5 clk = ~clk;

    bmr_tdee_qsys_nios2_qsys_0_div_cell dut (
        .clk           (clk),
        .reset         (reset),
        .A_div_start   (start),
        .A_div_signed  (sgn),
        .A_div_src1    (src1),
        .A_div_src2    (src2),
        .A_div_busy    (busy),
        .A_div_done    (done),
        .A_div_quot    (quot),
        .A_div_rem     (rem),
        .A_div_by_zero (by_zero)
    );

    typedef struct {
        logic [31:0] a, b;
        logic        s;
        logic [31:0] q, r;
        logic        z;
    } vec_t;

    vec_t vecs[10];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference from the arithmetic definition of div/divu.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        int sa, sb;
        z = (b == 0);
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0;
        end else begin
            sa = a; sb = b;
            q = 32'(sa / sb); r = 32'(sa % sb);
        end
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        src1 = a; src2 = b; sgn = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        src1 = $urandom; src2 = $urandom; sgn = ~s;
    endtask

    // Counts cycles after the start edge until done. kind 1 pulses a stray start in
    // cycle 4 (sampled at edge 5); kind 2 raises reset in cycle 10 and returns.
    task automatic wait_done(input int kind, output int cyc, output logic busy_ok);
        cyc = 0; busy_ok = 1'b1;
        while (cyc < 60) begin
            @(negedge clk);
            start = 1'b0;
            if (kind == 2 && cyc == 10) begin
                reset = 1'b1;
                break;
            end
            if (kind == 1 && cyc == 4) begin
                start = 1'b1; src1 = 32'd1000; src2 = 32'd10; sgn = 1'b0;
            end
            if (busy !== (cyc >= 1)) busy_ok = 1'b0;
            if (done === 1'b1) break;
            cyc++;
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v, input int kind);
        int   cyc;
        logic bok;
        launch(v.a, v.b, v.s);
        wait_done(kind, cyc, bok);
        chk({nm, " latency"}, cyc, 34);
        chk({nm, " busy window"}, bok, 1);
        chk({nm, " quot"}, quot, v.q);
        chk({nm, " rem"}, rem, v.r);
        chk({nm, " by_zero"}, by_zero, v.z);
    endtask

    initial begin
        int   cyc, ndone;
        logic bok;
        logic [31:0] a, b, eq, er;
        logic s, ez;
        vec_t v;

        vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
        vecs[1] = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0};
        vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0};
        vecs[5] = '{32'h1234,      32'd0,         1'b1, 32'hFFFF_FFFF, 32'h1234,      1'b1};
        vecs[6] = '{32'h1234,      32'd0,         1'b0, 32'hFFFF_FFFF, 32'h1234,      1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1,         32'h7FFF_FFFE, 1'b0};
        vecs[8] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0};
        vecs[9] = '{32'd9,         32'd3,         1'b0, 32'd3,         32'd0,         1'b0};

        reset = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset quot", quot, 0);
        chk("reset rem", rem, 0);
        chk("reset by_zero", by_zero, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 0);
            @(negedge clk);
            chk($sformatf("vec%0d done pulse width", i), done, 0);
            chk($sformatf("vec%0d busy drop", i), busy, 0);
        end

        // Stray start while busy must not disturb the running 100/7.
        run_vec("ignored start", vecs[0], 1);

        // Start in the done cycle is accepted and completes 34 cycles later.
        run_vec("back2back first", vecs[1], 0);
        src1 = 32'd9; src2 = 32'd3; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, cyc, bok);
        chk("back2back latency", cyc, 34);
        chk("back2back busy window", bok, 1);
        chk("back2back quot", quot, 3);
        chk("back2back rem", rem, 0);

        // Reset mid-operation aborts without a done pulse.
        launch(32'hDEAD, 32'd7, 1'b0);
        wait_done(2, cyc, bok);
        @(negedge clk);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset quot", quot, 0);
        chk("midreset rem", rem, 0);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("midreset stray done", ndone, 0);
        run_vec("after reset 9/3", vecs[9], 0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            s = 1'($urandom_range(0, 1));
            model(a, b, s, eq, er, ez);
            v = '{a, b, s, eq, er, ez};
            run_vec($sformatf("rand%0d %h/%h s=%0b", i, a, b, s), v, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
